// File: rtl/pipe_ctrl.sv
// pipe_ctrl: issue/stall/flush control for an in-order pipeline, tracking pending register writes.
// Optional PIPE_CTRL_FWD_EN: with forwarding only load-use stalls; the default build stalls on any pending write.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_idx_i,
  input  logic [4:0] id_rs2_idx_i,
  input  logic [4:0] id_rd_idx_i,
  input  logic       id_wben_i,
  input  logic       id_is_load_i,
  input  logic       id_is_mc_i,
  input  logic       ex_redirect_i,
  input  logic       mc_done_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rdid_i,
  output logic       stalln_pc,
  output logic       stalln_id,
  output logic       stalln_ex,
  output logic       flush_id_o,
  output logic       flush_ex_o,
  output logic       issue_o,
  output logic       mc_busy_o
);

  typedef enum logic [1:0] {S_RUN, S_LU, S_MC} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt [32];
  logic       hazard, lu_haz, rd_full;

  // A writer whose counter is saturated must wait, so counters never wrap.
  assign rd_full = id_wben_i && (id_rd_idx_i != '0) && (cnt[id_rd_idx_i] == 2'd3);

`ifdef PIPE_CTRL_FWD_EN
  logic       ld_v;
  logic [4:0] ld_rd;

  assign lu_haz = ld_v && (ld_rd != '0) &&
                  ((ld_rd == id_rs1_idx_i) || (ld_rd == id_rs2_idx_i));
  assign hazard = lu_haz || rd_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_v  <= 1'b0;
      ld_rd <= '0;
    end else begin
      ld_v <= issue_o && id_is_load_i;
      if (issue_o && id_is_load_i)
        ld_rd <= id_rd_idx_i;
    end
  end
`else
  logic unused_load;

  assign unused_load = id_is_load_i;
  assign lu_haz      = 1'b0;
  assign hazard      = ((id_rs1_idx_i != '0) && (cnt[id_rs1_idx_i] != '0)) ||
                       ((id_rs2_idx_i != '0) && (cnt[id_rs2_idx_i] != '0)) ||
                       rd_full;
`endif

  always_comb begin
    stalln_pc  = 1'b1;
    stalln_id  = 1'b1;
    stalln_ex  = 1'b1;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    issue_o    = 1'b0;
    state_nxt  = state;
    if (!rst_n) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
      state_nxt  = S_RUN;
    end else if (state == S_MC) begin
      if (mc_done_i) begin
        state_nxt = S_RUN;
      end else begin
        stalln_pc = 1'b0;
        stalln_id = 1'b0;
        stalln_ex = 1'b0;
      end
    end else begin
      // S_LU is entered with the bubble already inserted; ld_v is clear there, so
      // the load-use term drops and the waiting instruction issues in that cycle.
      state_nxt = S_RUN;
      if (ex_redirect_i) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (id_valid_i && hazard) begin
        stalln_pc  = 1'b0;
        stalln_id  = 1'b0;
        flush_ex_o = 1'b1;
        if (lu_haz)
          state_nxt = S_LU;
      end else if (id_valid_i) begin
        issue_o = 1'b1;
        if (id_is_mc_i)
          state_nxt = S_MC;
      end
    end
  end

  assign mc_busy_o = rst_n && (state == S_MC);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= S_RUN;
    else
      state <= state_nxt;
  end

  // Simultaneous issue and retire of the same register cancel out.
  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (!rst_n)
        cnt[i] <= '0;
      else if ((issue_o && id_wben_i && (id_rd_idx_i == 5'(i))) &&
               !(wb_valid_i && (wb_rdid_i == 5'(i))))
        cnt[i] <= cnt[i] + 2'd1;
      else if ((wb_valid_i && (wb_rdid_i == 5'(i))) &&
               !(issue_o && id_wben_i && (id_rd_idx_i == 5'(i))) &&
               (cnt[i] != '0))
        cnt[i] <= cnt[i] - 2'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl issue/stall/flush behaviour.
// Output vector order: {stalln_pc, stalln_id, stalln_ex, flush_id_o, flush_ex_o, issue_o, mc_busy_o}.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_i;
  logic [4:0] id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i;
  logic       id_wben_i, id_is_load_i, id_is_mc_i;
  logic       ex_redirect_i, mc_done_i, wb_valid_i;
  logic [4:0] wb_rdid_i;
  logic       stalln_pc, stalln_id, stalln_ex;
  logic       flush_id_o, flush_ex_o, issue_o, mc_busy_o;
  logic [6:0] outs;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  localparam logic [6:0] O_RST  = 7'b1111100;
  localparam logic [6:0] O_IDLE = 7'b1110000;
  localparam logic [6:0] O_ISS  = 7'b1110010;
  localparam logic [6:0] O_STL  = 7'b0010100;
  localparam logic [6:0] O_MC   = 7'b0000001;
  localparam logic [6:0] O_DONE = 7'b1110001;

  pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid_i   (id_valid_i),
    .id_rs1_idx_i (id_rs1_idx_i),
    .id_rs2_idx_i (id_rs2_idx_i),
    .id_rd_idx_i  (id_rd_idx_i),
    .id_wben_i    (id_wben_i),
    .id_is_load_i (id_is_load_i),
    .id_is_mc_i   (id_is_mc_i),
    .ex_redirect_i(ex_redirect_i),
    .mc_done_i    (mc_done_i),
    .wb_valid_i   (wb_valid_i),
    .wb_rdid_i    (wb_rdid_i),
    .stalln_pc    (stalln_pc),
    .stalln_id    (stalln_id),
    .stalln_ex    (stalln_ex),
    .flush_id_o   (flush_id_o),
    .flush_ex_o   (flush_ex_o),
    .issue_o      (issue_o),
    .mc_busy_o    (mc_busy_o)
  );

  assign outs = {stalln_pc, stalln_id, stalln_ex, flush_id_o, flush_ex_o, issue_o, mc_busy_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    #1;
    check(tag, 32'(outs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid_i    = 1'b0;
    id_rs1_idx_i  = '0;
    id_rs2_idx_i  = '0;
    id_rd_idx_i   = '0;
    id_wben_i     = 1'b0;
    id_is_load_i  = 1'b0;
    id_is_mc_i    = 1'b0;
    ex_redirect_i = 1'b0;
    mc_done_i     = 1'b0;
    wb_valid_i    = 1'b0;
    wb_rdid_i     = '0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wben, input logic ld, input logic mc);
    id_valid_i   = 1'b1;
    id_rs1_idx_i = rs1;
    id_rs2_idx_i = rs2;
    id_rd_idx_i  = rd;
    id_wben_i    = wben;
    id_is_load_i = ld;
    id_is_mc_i   = mc;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid_i = 1'b1;
    wb_rdid_i  = r;
  endtask

  task automatic nowb();
    wb_valid_i = 1'b0;
    wb_rdid_i  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", O_RST);
    rst_n = 1'b1;
    idle();
    chk("idle_after_reset", O_IDLE);
    tick();

`ifdef PIPE_CTRL_FWD_EN
    instr(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("addi_x7", O_ISS);
    tick();
    instr(5'd7, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0);
    chk("fwd_no_stall", O_ISS);
    tick();
    idle(); wb(5'd7);
    tick();
    nowb();
    instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("ld_x5", O_ISS);
    tick();
    instr(5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("lu_rs1_stall", O_STL);
    tick();
    chk("lu_rs1_issue", O_ISS);
    tick();
    instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("ld_x5_again", O_ISS);
    tick();
    instr(5'd1, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("lu_rs2_stall", O_STL);
    tick();
    chk("lu_rs2_issue", O_ISS);
    tick();
    idle(); wb(5'd5);
    tick();
    tick();
    nowb();
`else
    instr(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("addi_x7", O_ISS);
    tick();
    instr(5'd7, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0);
    chk("raw_x7_stall", O_STL);
    tick();
    chk("raw_x7_hold", O_STL);
    tick();
    wb(5'd7);
    chk("raw_x7_wb_cycle", O_STL);
    tick();
    nowb();
    chk("raw_x7_issue", O_ISS);
    tick();
    instr(5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    chk("w12", O_ISS);
    tick();
    instr(5'd0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
    wb(5'd12);
    chk("raw_rs2_stall", O_STL);
    tick();
    nowb();
    chk("raw_rs2_issue", O_ISS);
    tick();
`endif

    // Counter saturation on x3.
    instr(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("w3_a", O_ISS);
    tick();
    chk("w3_b", O_ISS);
    tick();
    wb(5'd3);
    chk("w3_c_with_wb", O_ISS);
    tick();
    nowb();
    chk("w3_d", O_ISS);
    tick();
    chk("w3_full_block", O_STL);
    tick();
    wb(5'd3);
    chk("w3_full_wb_cycle", O_STL);
    tick();
    nowb();
    chk("w3_refill", O_ISS);
    tick();
    idle(); wb(5'd3);
    repeat (4) tick();
    nowb();
    instr(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("x3_drained", O_ISS);
    tick();

    // Redirect beats a hazard.
    instr(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    chk("ld_x7", O_ISS);
    tick();
    instr(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ex_redirect_i = 1'b1;
    chk("redir_over_hazard", O_RST);
    tick();
    ex_redirect_i = 1'b0;
`ifdef PIPE_CTRL_FWD_EN
    chk("after_redir_no_lu", O_ISS);
    tick();
    idle(); wb(5'd7);
    tick();
    nowb();
`else
    wb(5'd7);
    chk("after_redir_stall", O_STL);
    tick();
    nowb();
    chk("after_redir_issue", O_ISS);
    tick();
`endif
    idle();
    ex_redirect_i = 1'b1;
    chk("redir_idle", O_RST);
    tick();
    ex_redirect_i = 1'b0;

    // Multi-cycle op with a redirect that must be ignored.
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("div_issue", O_ISS);
    tick();
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      ex_redirect_i = (i == 5);
      chk($sformatf("mc_wait%0d", i), O_MC);
      tick();
    end
    ex_redirect_i = 1'b0;
    mc_done_i = 1'b1;
    chk("mc_done_release", O_DONE);
    tick();
    mc_done_i = 1'b0;
    chk("mc_exit_issue", O_ISS);
    tick();

    // Reset during a multi-cycle wait with x9 pending twice.
    instr(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("w9_a", O_ISS);
    tick();
    chk("w9_b", O_ISS);
    tick();
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("div2_issue", O_ISS);
    tick();
    instr(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mc_before_rst", O_MC);
    tick();
    rst_n = 1'b0;
    chk("rst_in_mc", O_RST);
    tick();
    rst_n = 1'b1;
    chk("post_rst_read_x9", O_ISS);
    tick();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
